// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencing controller.
package hazard_stall_controller_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned SEQ_W   = 4;
    localparam int unsigned INSTR_W = 32;

    // NOP loaded by IF/ID and ID/EX when flushed or bubbled (addi x0, x0, 0)
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BAD   = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_bubble;
        logic exmem_we;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
                                      idex_we: 1'b0, idex_bubble: 1'b1, exmem_we: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                      idex_we: 1'b0, idex_bubble: 1'b0, exmem_we: 1'b0};
    localparam ctrl_t CTRL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                      idex_we: 1'b1, idex_bubble: 1'b0, exmem_we: 1'b1};
    localparam ctrl_t CTRL_FLUSH  = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                      idex_we: 1'b1, idex_bubble: 1'b1, exmem_we: 1'b1};
    localparam ctrl_t CTRL_STALL  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                      idex_we: 1'b1, idex_bubble: 1'b1, exmem_we: 1'b1};

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and reset take priority over increment.
module hazard_stall_controller_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_stall_controller.sv
// Turns load-use hazard, taken-branch and memory-busy into per-stage enables, flushes
// and bubbles, with saturating stall/flush performance counters.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard,
    input  logic               branch_taken,
    input  logic               mem_busy,
    input  logic               cnt_clr,
    output logic               pc_we,
    output logic               ifid_we,
    output logic               ifid_flush,
    output logic               idex_we,
    output logic               idex_bubble,
    output logic               exmem_we,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   haz_stall_cnt,
    output logic [CNT_W-1:0]   mem_stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [SEQ_W-1:0] LOAD_RELOAD  = SEQ_W'(LOAD_LAT - 1);
    localparam logic [SEQ_W-1:0] FLUSH_RELOAD = SEQ_W'(FLUSH_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SEQ_W-1:0] r_cnt;
    logic [SEQ_W-1:0] w_cnt_nxt;
    ctrl_t            w_ctrl;
    logic             w_haz_inc;
    logic             w_mem_inc;
    logic             w_flush_inc;

    // Mealy control and next-state: rst > mem_busy > branch_taken > hazard
    always_comb begin
        w_ctrl      = CTRL_RUN;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_haz_inc   = 1'b0;
        w_mem_inc   = 1'b0;
        w_flush_inc = 1'b0;

        if (rst) begin
            w_ctrl      = CTRL_RESET;
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
        end else if (mem_busy) begin
            w_ctrl    = CTRL_FREEZE;
            w_mem_inc = 1'b1;
            if (r_state == ST_BAD) begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        end else if (branch_taken) begin
            w_ctrl      = CTRL_FLUSH;
            w_flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = ST_FLUSH;
                w_cnt_nxt   = FLUSH_RELOAD;
            end else begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    w_ctrl      = CTRL_FLUSH;
                    w_flush_inc = 1'b1;
                    if (r_cnt <= SEQ_W'(1)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - SEQ_W'(1);
                    end
                end
                ST_HAZ: begin
                    w_ctrl    = CTRL_STALL;
                    w_haz_inc = 1'b1;
                    if (r_cnt <= SEQ_W'(1)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - SEQ_W'(1);
                    end
                end
                default: begin
                    // RUN, and the unreachable encoding which behaves as RUN
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    if (hazard) begin
                        w_ctrl    = CTRL_STALL;
                        w_haz_inc = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = ST_HAZ;
                            w_cnt_nxt   = LOAD_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    hazard_stall_controller_sat_counter #(.WIDTH(CNT_W)) u_haz_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_haz_inc),
        .count (haz_stall_cnt)
    );

    hazard_stall_controller_sat_counter #(.WIDTH(CNT_W)) u_mem_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_mem_inc),
        .count (mem_stall_cnt)
    );

    hazard_stall_controller_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

    assign pc_we       = w_ctrl.pc_we;
    assign ifid_we     = w_ctrl.ifid_we;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_we     = w_ctrl.idex_we;
    assign idex_bubble = w_ctrl.idex_bubble;
    assign exmem_we    = w_ctrl.exmem_we;
    assign state_o     = r_state;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-count model.
module tb_hazard_stall_controller;

    localparam int unsigned LL   = 3;
    localparam int unsigned FC   = 2;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, hazard, branch_taken, mem_busy, cnt_clr;
    logic          pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we;
    logic [1:0]    state_o;
    logic [CW-1:0] haz_stall_cnt, mem_stall_cnt, flush_cnt;

    hazard_stall_controller #(.LOAD_LAT(LL), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .branch_taken  (branch_taken),
        .mem_busy      (mem_busy),
        .cnt_clr       (cnt_clr),
        .pc_we         (pc_we),
        .ifid_we       (ifid_we),
        .ifid_flush    (ifid_flush),
        .idex_we       (idex_we),
        .idex_bubble   (idex_bubble),
        .exmem_we      (exmem_we),
        .state_o       (state_o),
        .haz_stall_cnt (haz_stall_cnt),
        .mem_stall_cnt (mem_stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we}
    logic [5:0]      w_ctrl;
    logic [3*CW-1:0] w_cnts;
    assign w_ctrl = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we};
    assign w_cnts = {haz_stall_cnt, mem_stall_cnt, flush_cnt};

    // Model: remaining stall / flush cycles after the current one, and counter values
    int m_haz_left, m_fl_left, m_hc, m_mc, m_fc;
    int vectors, errors;

    logic [5:0]      e_ctrl;
    logic [1:0]      e_state;
    logic [3*CW-1:0] e_cnts;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Drive one cycle, capture the model's expectations for it, then advance the model
    task automatic cycle(input logic h, input logic b, input logic m, input logic c, input logic r);
        @(negedge clk);
        hazard = h; branch_taken = b; mem_busy = m; cnt_clr = c; rst = r;
        #1;
        e_state = (m_fl_left > 0) ? 2'd2 : ((m_haz_left > 0) ? 2'd1 : 2'd0);
        e_cnts  = {CW'(m_hc), CW'(m_mc), CW'(m_fc)};
        if (r)                           e_ctrl = 6'b001010;
        else if (m)                      e_ctrl = 6'b000000;
        else if (b || m_fl_left > 0)     e_ctrl = 6'b111111;
        else if (m_haz_left > 0 || h)    e_ctrl = 6'b000111;
        else                             e_ctrl = 6'b110101;

        if (r) begin
            m_haz_left = 0; m_fl_left = 0; m_hc = 0; m_mc = 0; m_fc = 0;
        end else begin
            if (m) begin
                m_mc = sat_inc(m_mc);
            end else if (b) begin
                m_fc = sat_inc(m_fc); m_fl_left = FC - 1; m_haz_left = 0;
            end else if (m_fl_left > 0) begin
                m_fc = sat_inc(m_fc); m_fl_left--;
            end else if (m_haz_left > 0) begin
                m_hc = sat_inc(m_hc); m_haz_left--;
            end else if (h) begin
                m_hc = sat_inc(m_hc); m_haz_left = LL - 1;
            end
            if (c) begin
                m_hc = 0; m_mc = 0; m_fc = 0;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (w_ctrl !== 6'b001010) begin
                errors++; $display("FAIL reset_ctrl cyc %0d: got %b exp 001010", i, w_ctrl);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d exp 0", state_o);
        end
        vectors++;
        if (w_cnts !== '0) begin
            errors++; $display("FAIL reset_cnts: got %h exp 0", w_cnts);
        end
        vectors++;
        if (w_ctrl !== e_ctrl) begin
            errors++; $display("FAIL reset_run_ctrl: got %b exp %b", w_ctrl, e_ctrl);
        end
    endtask

    task automatic test_load_use();
        logic [5:0] hs = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            cycle(hs[i], 1'b0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (w_ctrl !== e_ctrl) begin
                errors++; $display("FAIL load_use_ctrl cyc %0d: got %b exp %b", i, w_ctrl, e_ctrl);
            end
            vectors++;
            if (state_o !== e_state) begin
                errors++; $display("FAIL load_use_state cyc %0d: got %0d exp %0d", i, state_o, e_state);
            end
        end
        vectors++;
        if (haz_stall_cnt !== CW'(LL)) begin
            errors++; $display("FAIL load_use_cnt: got %0d exp %0d", haz_stall_cnt, LL);
        end
    endtask

    task automatic test_branch_flush();
        logic [6:0] bs = 7'b0000100;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, bs[i], 1'b0, 1'b0, 1'b0);
            vectors++;
            if (w_ctrl !== e_ctrl) begin
                errors++; $display("FAIL branch_ctrl cyc %0d: got %b exp %b", i, w_ctrl, e_ctrl);
            end
            vectors++;
            if (state_o !== e_state) begin
                errors++; $display("FAIL branch_state cyc %0d: got %0d exp %0d", i, state_o, e_state);
            end
        end
        vectors++;
        if (flush_cnt !== CW'(FC)) begin
            errors++; $display("FAIL branch_cnt: got %0d exp %0d", flush_cnt, FC);
        end
    endtask

    task automatic test_mem_freeze();
        logic [8:0] hs = 9'b000000001;
        logic [8:0] ms = 9'b000111100;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(hs[i], ms[i], ms[i], 1'b0, 1'b0);
            vectors++;
            if (w_ctrl !== e_ctrl) begin
                errors++; $display("FAIL freeze_ctrl cyc %0d: got %b exp %b", i, w_ctrl, e_ctrl);
            end
            vectors++;
            if (state_o !== e_state) begin
                errors++; $display("FAIL freeze_state cyc %0d: got %0d exp %0d", i, state_o, e_state);
            end
        end
        vectors++;
        if (w_cnts !== {CW'(LL), CW'(4), CW'(0)}) begin
            errors++; $display("FAIL freeze_cnts: got %h exp %h", w_cnts, {CW'(LL), CW'(4), CW'(0)});
        end
    endtask

    task automatic test_branch_and_hazard();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (w_ctrl !== 6'b111111) begin
            errors++; $display("FAIL both_ctrl: got %b exp 111111", w_ctrl);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (w_cnts !== e_cnts) begin
                errors++; $display("FAIL both_cnts cyc %0d: got %h exp %h", i, w_cnts, e_cnts);
            end
        end
        vectors++;
        if (haz_stall_cnt !== '0) begin
            errors++; $display("FAIL both_haz_cnt: got %0d exp 0", haz_stall_cnt);
        end
    endtask

    task automatic test_saturation();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (w_cnts !== e_cnts) begin
                errors++; $display("FAIL sat_cnts cyc %0d: got %h exp %h", i, w_cnts, e_cnts);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (haz_stall_cnt !== CW'(CMAX)) begin
            errors++; $display("FAIL sat_max: got %0d exp %0d", haz_stall_cnt, CMAX);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (haz_stall_cnt !== '0) begin
            errors++; $display("FAIL sat_clr_wins: got %0d exp 0", haz_stall_cnt);
        end
    endtask

    task automatic test_random();
        logic h, b, m, c, r;
        for (int i = 0; i < 400; i++) begin
            h = ($urandom_range(0, 99) < 35);
            b = ($urandom_range(0, 99) < 15);
            m = ($urandom_range(0, 99) < 20);
            c = ($urandom_range(0, 99) < 4);
            r = ($urandom_range(0, 99) < 2);
            cycle(h, b, m, c, r);
            vectors++;
            if (w_ctrl !== e_ctrl) begin
                errors++; $display("FAIL rand_ctrl cyc %0d: got %b exp %b", i, w_ctrl, e_ctrl);
            end
            vectors++;
            if (state_o !== e_state) begin
                errors++; $display("FAIL rand_state cyc %0d: got %0d exp %0d", i, state_o, e_state);
            end
            vectors++;
            if (w_cnts !== e_cnts) begin
                errors++; $display("FAIL rand_cnts cyc %0d: got %h exp %h", i, w_cnts, e_cnts);
            end
        end
    endtask

    initial begin
        rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
        vectors = 0; errors = 0;
        test_reset();
        test_load_use();
        test_branch_flush();
        test_mem_freeze();
        test_branch_and_hazard();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller that turns the load-use hazard flag from Conflict_Detector_unit, the EX-stage branch_taken and the memory-busy signal into per-stage write enables, flushes and bubbles.
- Sits between the hazard/branch logic and the IF/ID, ID/EX and EX/MEM pipeline registers plus the PC.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- LOAD_LAT, 1: bubble cycles inserted per load-use hazard; legal range 1..15.
- FLUSH_CYCLES, 1: cycles ifid_flush/idex_bubble are held after a taken branch; legal range 1..15.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard  in  1  load-use hazard, ID-stage instruction vs EX-stage load, from Conflict_Detector_unit.
- branch_taken  in  1  EX-stage branch/jump resolved taken this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must freeze.
- cnt_clr  in  1  synchronous clear of all performance counters.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_we  out  1  ID/EX register write enable.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_we  out  1  EX/MEM (and MEM/WB) write enable.
- state_o  out  2  current FSM state: RUN=0, HAZ=1, FLUSH=2.
- haz_stall_cnt  out  CNT_W  cycles spent stalling on load-use hazards.
- mem_stall_cnt  out  CNT_W  cycles frozen by mem_busy.
- flush_cnt  out  CNT_W  cycles spent flushing.

Behaviour:
- Control outputs are Mealy: a combinational function of state, cnt and inputs, so stalls take effect in the same cycle the condition appears. State, 4-bit cnt and counters are registered.
- Reset, while rst=1: pc_we=ifid_we=idex_we=exmem_we=0, ifid_flush=idex_bubble=1. Next edge: state=RUN, cnt=0, all counters 0. rst mid-stall or mid-flush aborts it immediately.
- Priority each cycle: rst > mem_busy > branch_taken > hazard.
- Freeze (mem_busy=1, any state):
  - All write enables 0; ifid_flush=idex_bubble=0.
  - state and cnt hold.
  - mem_stall_cnt increments.
  - branch_taken and hazard are ignored that cycle; the source stages are frozen, so the inputs persist.
- RUN:
  - Normal (no event): all we=1, flush=bubble=0.
  - branch_taken: pc_we=1 (loads target), ifid_flush=1, idex_bubble=1, exmem_we=1, flush_cnt++. If FLUSH_CYCLES>1: go FLUSH with cnt=FLUSH_CYCLES-1.
  - hazard (no branch): pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=1, haz_stall_cnt++. If LOAD_LAT>1: go HAZ with cnt=LOAD_LAT-1.
- HAZ:
  - Same outputs as the RUN hazard case; haz_stall_cnt++.
  - cnt decrements each unfrozen cycle; when cnt==1, go RUN.
  - branch_taken here: flush outputs apply, the stall is abandoned, and the next state is chosen as in RUN.
- FLUSH:
  - pc_we=1, ifid_flush=1, idex_bubble=1, exmem_we=1; flush_cnt++.
  - cnt decrements; at cnt==1, go RUN.
  - A new branch_taken here reloads cnt=FLUSH_CYCLES-1.
  - hazard is ignored in FLUSH; the ID instruction is being flushed.
- idex_we is 1 whenever not frozen; the bubble overrides its data.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr zeros them next edge; if cnt_clr and an increment coincide, clear wins.
  - rst also clears them.
- state_o reflects the registered state. Encoding 3 is unreachable; it recovers to RUN next edge, with outputs as in RUN.

Decomposition:
- Shared package: state encoding constants (RUN/HAZ/FLUSH) and the NOP instruction constant used by the pipeline registers.
- One sub-module, sat_counter (width CNT_W, inc, clr, rst), instantiated three times.

Test Plan:
- rst held 3 cycles with hazard=1 and branch_taken=1 -> all we=0, flush=bubble=1 during rst; after release, state_o=0 and all counters=0.
- LOAD_LAT=2, hazard pulse 1 cycle in RUN -> pc_we=ifid_we=0 and idex_bubble=1 for exactly 2 cycles, then RUN; haz_stall_cnt=2.
- FLUSH_CYCLES=2, branch_taken in cycle 5 -> ifid_flush=idex_bubble=1 in cycles 5-6, pc_we=1 throughout; flush_cnt=2.
- mem_busy=1 for 4 cycles during a HAZ stall with cnt=1 -> all we=0 for 4 cycles, state/cnt held, then 1 more HAZ cycle; mem_stall_cnt=4.
- branch_taken and hazard asserted together in RUN -> flush wins: pc_we=1, ifid_flush=1; haz_stall_cnt unchanged.
- CNT_W=4, 20 hazard cycles -> haz_stall_cnt saturates at 15. cnt_clr together with a hazard -> counter reads 0 next cycle.
